// File: rtl/imem_loader.sv
// Instruction-memory program loader.
// Accepts a framed byte stream (SYNC, COUNT, 2*COUNT payload bytes, XOR checksum),
// writes big-endian 16-bit words to sequential addresses, and keeps the
// pipeline in reset until a frame with a matching checksum has been loaded.
module imem_loader #(
    parameter int         ADDR_W    = 4,
    parameter int         INSTR_W   = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               load_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_HI, S_LO, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] index;
    logic [8:0]        remaining;
    logic [7:0]        hi_byte;
    logic [7:0]        chk_acc;
    logic              accept;
    logic              count_ok;

    assign accept   = rx_valid & rx_ready;
    // A word count of zero, or one that would overrun memory, is rejected up front
    // so the write index can never wrap.
    assign count_ok = (rx_data != 8'd0) && (32'(rx_data) <= DEPTH);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; every transition is gated by an accepted byte.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                S_IDLE:  if (rx_data == SYNC_BYTE) state_nxt = S_COUNT;
                S_COUNT: state_nxt = count_ok ? S_HI : S_ERR;
                S_HI:    state_nxt = S_LO;
                S_LO:    state_nxt = (remaining == 9'd1) ? S_CHK : S_HI;
                S_CHK:   state_nxt = (rx_data == chk_acc) ? S_DONE : S_ERR;
                S_ERR:   if (rx_data == SYNC_BYTE) state_nxt = S_COUNT;
                default: state_nxt = state;
            endcase
        end
    end

    // Status outputs are pure functions of the state; DONE is the only state
    // that releases the pipeline and refuses further bytes.
    always_comb begin
        rx_ready  = (state != S_DONE);
        cpu_hold  = (state != S_DONE);
        load_done = (state == S_DONE);
        load_err  = (state == S_ERR);
    end

    // Frame datapath: index, remaining count, checksum and the registered write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index     <= '0;
            remaining <= '0;
            hi_byte   <= '0;
            chk_acc   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                case (state)
                    S_IDLE, S_ERR: begin
                        if (rx_data == SYNC_BYTE) begin
                            index   <= '0;
                            chk_acc <= '0;
                        end
                    end
                    S_COUNT: begin
                        if (count_ok) remaining <= {1'b0, rx_data};
                    end
                    S_HI: begin
                        hi_byte <= rx_data;
                        chk_acc <= chk_acc ^ rx_data;
                    end
                    S_LO: begin
                        // Address and data stay put after the pulse until the next word.
                        chk_acc   <= chk_acc ^ rx_data;
                        mem_we    <= 1'b1;
                        mem_addr  <= index;
                        mem_wdata <= {hi_byte, rx_data};
                        index     <= index + 1'b1;
                        remaining <= remaining - 9'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Stream-to-memory program loader that writes the instruction memory read by the four-stage pipeline. The pipeline is the reader of instruction memory; this block is its writer. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 16-bit instructions. It writes them to sequential instruction-memory addresses, verifies an XOR checksum, and holds the processor in reset until a good program has been loaded.

Parameters:
ADDR_W, 4, instruction-memory address width; DEPTH = 2**ADDR_W entries.
INSTR_W, 16, instruction width; fixed at 2 bytes, other values unsupported.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
rx_data  input  8  incoming stream byte.
rx_valid  input  1  rx_data is valid.
rx_ready  output  1  loader can accept a byte; a transfer occurs when rx_valid & rx_ready at a rising edge.
mem_we  output  1  instruction-memory write strobe, one-cycle pulse.
mem_addr  output  ADDR_W  write address.
mem_wdata  output  INSTR_W  write data.
cpu_hold  output  1  1 = pipeline held in reset; drives the pipeline reset.
load_done  output  1  sticky; set when a frame completes with a good checksum.
load_err  output  1  sticky until the next SYNC_BYTE; set on a bad count or bad checksum.

Behaviour:
- Frame format: SYNC_BYTE, COUNT (N), then 2N instruction bytes (high byte first), then CHK.
- N must satisfy 1 ≤ N ≤ DEPTH.
- CHK = XOR of the 2N instruction bytes only. SYNC and COUNT are excluded.
- Reset (reset=0, asynchronous):
  - state=IDLE, rx_ready=1, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1, load_done=0, load_err=0.
  - Internal index, remaining count, high-byte register and checksum accumulator are all cleared.
- Reset asserted mid-frame aborts the frame immediately. Words already written stay in memory; cpu_hold remains 1.
- States and transitions (each transition occurs only on an accepted byte):
  - IDLE: byte == SYNC_BYTE → COUNT. Clear index, checksum and load_err. Any other byte is discarded.
  - COUNT: N==0 or N>DEPTH → ERR. Otherwise latch N → HI.
  - HI: store the byte as the high byte, XOR it into the checksum → LO.
  - LO: form {hi, byte}, XOR the byte into the checksum. Register a write: next cycle mem_we=1, mem_addr=index, mem_wdata=word. Then index+1, remaining−1. Go to CHK if remaining was 1, else HI.
  - CHK: byte == checksum → DONE, else → ERR.
  - DONE: load_done=1, cpu_hold=0, rx_ready=0. Absorbing state; only reset leaves it.
  - ERR: load_err=1, cpu_hold=1, rx_ready=1. A SYNC_BYTE → COUNT (clears load_err). Other bytes are discarded.
- rx_ready is 1 in every state except DONE. The loader never stalls mid-frame.
- Write latency: mem_we pulses exactly one cycle after the LO handshake edge.
  - mem_addr/mem_wdata hold their values after the pulse until the next write.
  - Back-to-back bytes give at most one write per two cycles, so there is no write overlap.
- Words are written before the checksum is checked. A bad frame leaves partial or garbage memory contents, but cpu_hold=1 prevents execution.
- Index never wraps: the COUNT check guarantees index ≤ DEPTH−1 at every write. With N=DEPTH the last write is to address DEPTH−1.
- rx_valid=0 in any state: no state change, no write. Arbitrary gaps between bytes are legal.
- A SYNC_BYTE value inside the payload is treated as data; there is no resync mid-frame.
- cpu_hold deasserts in the same cycle that load_done asserts: the edge after the CHK byte is accepted.

Test Plan:
- Good load: stream A5,02,12,98,29,70,D3 (ADD R1,R2,R3 = 0x1298; SUB R4,R5,R6 = 0x2970) → writes addr0=0x1298 and addr1=0x2970, each mem_we one cycle after its low byte. Then load_done=1, cpu_hold=0, rx_ready=0.
- Bad checksum: same stream with final byte 00 → both writes occur, load_err=1, load_done=0, cpu_hold=1. Then resend the good frame → load_err clears on A5, load_done=1.
- Bad count: A5,00 and, in a separate run, A5,11 (17 > DEPTH=16) → ERR after the COUNT byte with no mem_we. Following bytes are discarded until A5.
- Full depth with gaps: N=16, words 0x0000–0x000F with random rx_valid gaps → 16 writes to addresses 0–15, the last at addr 15. Correct CHK → DONE.
- Preamble noise and in-payload A5: bytes 00,FF,A5,01,A5,A5,00 → 00 and FF ignored; addr0=0xA5A5 written; checksum 00 matches; DONE.
- Mid-frame reset: drop reset low after A5,02,12 → outputs return to reset values immediately. A subsequent good frame loads normally.
